bus_rr_sched: RTL and testbench
===============================

Name: bus_rr_sched

Overview:
- Round-robin transfer scheduler for the shared multi-driver packet bus.
- Each of `drvrs` terminals exposes an input FIFO (`pndng`/`pop`/`D_pop`) and an output FIFO (`push`/`D_push`). The scheduler grants one pending source at a time, pops one packet, decodes its destination ID and pushes it to the addressed terminal, or to all other terminals on broadcast.
- Sits between the driver FIFOs and the terminal receive FIFOs. It is the sequencing core of the bus fabric.

Parameters:
- drvrs, 4, number of terminals (2..16).
- pckg_sz, 16, packet width in bits (>= ID_W+1).
- ID_W, 8, destination ID field width, located at `pckg[pckg_sz-1 -: ID_W]`.
- broadcast, {8{1'b1}}, destination ID meaning "all terminals except source".

Ports:
- clk, input, 1, bus clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- pndng, input, drvrs, bit i high = terminal i input FIFO non-empty; `D_pop` slice valid while high.
- D_pop, input, drvrs*pckg_sz, head packet of each input FIFO; slice i is bits `[i*pckg_sz +: pckg_sz]`.
- pop, output, drvrs, one-hot, 1-cycle pulse dequeuing the granted FIFO.
- push, output, drvrs, 1-cycle push strobe per destination terminal.
- D_push, output, pckg_sz, shared bus data; valid when any push bit is high.
- busy, output, 1, high in any state other than IDLE.
- grant_id, output, 4, index of the current/last granted terminal.
- err_drop, output, 1, 1-cycle pulse when a packet is discarded.
- xfer_cnt, output, 32, count of delivered packets; a broadcast counts as 1.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE.
  - pop, push, D_push, busy, err_drop, xfer_cnt = 0.
  - grant_id = drvrs-1, so the first grant starts search at terminal 0.
- Reset asserted mid-transfer aborts it: no pop or push is issued after reset. A packet already popped is lost by design.
- All outputs are registered.

FSM states: IDLE, POP, PUSH.
- IDLE:
  - If `pndng != 0`, select g = first set bit searching from (grant_id+1) mod drvrs upward with wrap.
  - Register grant_id = g and go to POP. Otherwise stay in IDLE.
- POP:
  - Assert `pop[g]` for exactly 1 cycle.
  - Latch `pkt = D_pop[g]` at the end of this cycle.
  - Go to PUSH.
- PUSH:
  - Decode `dst = pkt[pckg_sz-1 -: ID_W]`.
  - If dst == broadcast: `push = ~(1<<g)` masked to drvrs.
  - Else if dst < drvrs and dst != g: `push = 1<<dst`.
  - Otherwise (dst out of range, or dst == source): push = 0 and err_drop = 1.
  - D_push = pkt. xfer_cnt += 1 when push != 0; the counter wraps at 2^32.
  - Return to IDLE.

Timing and fairness:
- Latency: pndng high sampled at edge k → pop high in cycle k+1 → push high in cycle k+2.
- Peak throughput is 1 packet per 3 cycles.
- Fairness: with all terminals pending continuously, grants rotate 0,1,2,…,drvrs-1,0. Worst-case wait for any requester is drvrs transfers.
- Grant is based only on pndng sampled in IDLE. pndng changes during POP/PUSH are ignored until the next IDLE.

Boundary conditions:
- Source FIFOs must not drop pndng without a pop; the scheduler does not re-check pndng in POP.
- D_push holds its last value outside PUSH; consumers qualify it with push.
- A single pending terminal is granted repeatedly, once every 3 cycles.

Decomposition:
- Package bus_sched_pkg:
  - `sched_state_e` enum {IDLE, POP, PUSH}.
  - Localparams ID_W and BCAST_ID.
  - Function `dst_mask(dst, src, drvrs)` returning the push mask.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: gnt_idx, gnt_vld.
  - Purely combinational rotate-priority pick, reused by later bus variants.

Test Plan (drvrs=4, pckg_sz=16):
- Reset, then `pndng=4'b0001`, `D_pop[0]=16'h0212` → pop=0001 at +1 cycle; push=0100 with D_push=16'h0212 at +2 cycles; xfer_cnt=1; busy high for 2 cycles.
- `pndng=4'b1111`, held pending for 8 transfers → grant_id sequence 0,1,2,3,0,1,2,3; each pop one-hot; each push matches its packet's destination.
- Terminal 2 sends 16'hFFAB → push=1011, D_push=16'hFFAB; xfer_cnt increments by exactly 1.
- Terminal 1 sends 16'h0733 (dst 7 >= drvrs), then 16'h0155 (dst == src) → err_drop pulses once per packet, push stays 0, xfer_cnt unchanged, both FIFOs still popped.
- Assert reset during POP (`pop[3]` high) → pop, push, busy = 0 immediately; no push in the following cycles; after release the first grant goes to terminal 0 if it is pending.
- Preload xfer_cnt path with 2^32-1 transfers (force), then one more transfer → xfer_cnt wraps to 0.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared types, constants and destination decode for the packet bus scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {IDLE, POP, PUSH} sched_state_e;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = '1;

    // Push mask for a packet from src; an all-zero result means the packet is dropped.
    function automatic logic [15:0] dst_mask(
        input int unsigned dst,
        input int unsigned src,
        input int unsigned n,
        input int unsigned bcast
    );
        logic [16:0] all_m;
        all_m = (17'd1 << n) - 17'd1;
        if (dst == bcast) return all_m[15:0] & ~(16'd1 << src);
        if (dst < n && dst != src) return 16'd1 << dst;
        return '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick, searching upward from last+1 with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);

    localparam int W = $clog2(N);

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = last;
        gnt_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                gnt_idx = W'((int'(last) + k) % N);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin scheduler moving one packet at a time from a pending
// input FIFO to its addressed terminal(s) over the shared bus.
module bus_rr_sched #(
    parameter int drvrs = 4,
    parameter int pckg_sz = 16,
    parameter int ID_W = bus_sched_pkg::ID_W,
    parameter logic [ID_W-1:0] broadcast = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic                       busy,
    output logic [3:0]                 grant_id,
    output logic                       err_drop,
    output logic [31:0]                xfer_cnt
);

    import bus_sched_pkg::*;

    localparam int LW = $clog2(drvrs);

    sched_state_e       state, state_n;
    logic [LW-1:0]      g, g_n, arb_idx;
    logic               arb_vld;
    logic [pckg_sz-1:0] head, D_push_n;
    logic [ID_W-1:0]    dst;
    logic [drvrs-1:0]   mask, pop_n, push_n;
    logic               err_n;
    logic [31:0]        cnt_n;

    rr_arbiter #(.N(drvrs)) u_arb (
        .req     (pndng),
        .last    (g),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // The head is decoded while still in POP so every output can be registered into PUSH.
    assign head     = D_pop[int'(g)*pckg_sz +: pckg_sz];
    assign dst      = head[pckg_sz-1 -: ID_W];
    assign mask     = drvrs'(dst_mask(32'(dst), 32'(g), drvrs, 32'(broadcast)));
    assign grant_id = 4'(g);

    always_comb begin
        state_n  = state;
        g_n      = g;
        pop_n    = '0;
        push_n   = '0;
        D_push_n = D_push;
        err_n    = 1'b0;
        cnt_n    = xfer_cnt;
        case (state)
            IDLE: if (arb_vld) begin
                state_n = POP;
                g_n     = arb_idx;
                pop_n   = drvrs'(1) << arb_idx;
            end
            POP: begin
                state_n  = PUSH;
                push_n   = mask;
                D_push_n = head;
                err_n    = (mask == '0);
                cnt_n    = xfer_cnt + 32'(mask != '0);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g        <= LW'(drvrs - 1);
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            err_drop <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state    <= state_n;
            g        <= g_n;
            pop      <= pop_n;
            push     <= push_n;
            D_push   <= D_push_n;
            busy     <= (state_n != IDLE);
            err_drop <= err_n;
            xfer_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: directed table of transfers plus reset-abort and counter-wrap sequences.
module tb_bus_rr_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pndng = '0;
    logic [63:0] D_pop = '0;
    logic [3:0]  pop, push, grant_id;
    logic [15:0] D_push;
    logic        busy, err_drop;
    logic [31:0] xfer_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] cnt = '0;

    typedef struct {
        logic [3:0]  pndng;
        logic [63:0] dpop;
        int          g;
        logic [3:0]  push;
        logic        err;
    } vec_t;

    localparam logic [63:0] BASE = {16'h0103, 16'h0002, 16'h0301, 16'h0212};

    vec_t vecs[15];

    bus_rr_sched #(.drvrs(4), .pckg_sz(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id),
        .err_drop (err_drop),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the PUSH cycle.
    task automatic run(input vec_t v);
        logic [3:0]  ep;
        logic [15:0] pkt;
        ep  = 4'b1 << v.g;
        pkt = v.dpop[v.g*16 +: 16];
        pndng = v.pndng;
        D_pop = v.dpop;
        @(posedge clk); @(negedge clk);
        chk("pop", pop, ep);
        chk("grant_id", grant_id, v.g);
        chk("busy_pop", busy, 1);
        chk("push_in_pop", push, 0);
        @(posedge clk); @(negedge clk);
        if (v.push != 0) cnt = cnt + 1;
        chk("push", push, v.push);
        chk("D_push", D_push, pkt);
        chk("err_drop", err_drop, v.err);
        chk("xfer_cnt", xfer_cnt, cnt);
        chk("pop_in_push", pop, 0);
        chk("busy_push", busy, 1);
        @(posedge clk); @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("push_idle", push, 0);
        chk("err_idle", err_drop, 0);
    endtask

    initial begin
        vecs[0]  = '{4'b0001, BASE, 0, 4'b0100, 1'b0};
        vecs[1]  = '{4'b1111, BASE, 1, 4'b1000, 1'b0};
        vecs[2]  = '{4'b1111, BASE, 2, 4'b0001, 1'b0};
        vecs[3]  = '{4'b1111, BASE, 3, 4'b0010, 1'b0};
        vecs[4]  = '{4'b1111, BASE, 0, 4'b0100, 1'b0};
        vecs[5]  = '{4'b1111, BASE, 1, 4'b1000, 1'b0};
        vecs[6]  = '{4'b1111, BASE, 2, 4'b0001, 1'b0};
        vecs[7]  = '{4'b1111, BASE, 3, 4'b0010, 1'b0};
        vecs[8]  = '{4'b1111, BASE, 0, 4'b0100, 1'b0};
        vecs[9]  = '{4'b0100, {16'h0103, 16'hFFAB, 16'h0301, 16'h0212}, 2, 4'b1011, 1'b0};
        vecs[10] = '{4'b0010, {16'h0103, 16'h0002, 16'h0733, 16'h0212}, 1, 4'b0000, 1'b1};
        vecs[11] = '{4'b0010, {16'h0103, 16'h0002, 16'h0155, 16'h0212}, 1, 4'b0000, 1'b1};
        vecs[12] = '{4'b1001, BASE, 3, 4'b0010, 1'b0};
        vecs[13] = '{4'b1001, BASE, 0, 4'b0100, 1'b0};
        vecs[14] = '{4'b0001, {16'h0103, 16'h0002, 16'h0301, 16'hFF00}, 0, 4'b1110, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_D_push", D_push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_drop, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_grant", grant_id, 3);

        for (int i = 0; i < 15; i++) run(vecs[i]);

        // Reset while terminal 3 is being popped: everything clears and the search restarts at 0.
        pndng = 4'b1000;
        D_pop = BASE;
        @(posedge clk); @(negedge clk);
        chk("abort_pop_before", pop, 4'b1000);
        reset = 1'b1;
        #1;
        chk("abort_pop", pop, 0);
        chk("abort_push", push, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant_id, 3);
        pndng = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_push", push, 0);
            chk("abort_hold_pop", pop, 0);
        end
        reset = 1'b0;
        cnt = '0;
        run('{4'b1001, BASE, 0, 4'b0100, 1'b0});

        // Counter wrap at 2^32.
        pndng = 4'b0000;
        force dut.xfer_cnt = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        release dut.xfer_cnt;
        @(posedge clk); @(negedge clk);
        chk("preload_cnt", xfer_cnt, 32'hFFFF_FFFF);
        cnt = 32'hFFFF_FFFF;
        run('{4'b0001, BASE, 0, 4'b0100, 1'b0});
        chk("wrap_cnt", xfer_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
